// File: rtl/spi_pwm_multi_if.sv
// Pin bundle for the SPI-configured PWM controller: SPI slave pins in, channel outputs and
// frame status pulses out.
interface spi_pwm_multi_if #(
  parameter int NUM_CH = 16
);
  logic              sclk_in;
  logic              copi_in;
  logic              ncs_in;
  logic [NUM_CH-1:0] out;
  logic              frame_done;
  logic              frame_err;

  modport master (
    output sclk_in, copi_in, ncs_in,
    input  out, frame_done, frame_err
  );

  modport slave (
    input  sclk_in, copi_in, ncs_in,
    output out, frame_done, frame_err
  );
endinterface

// File: rtl/spi_pwm_multi.sv
// Write-only SPI slave feeding a register file that drives NUM_CH off/high/PWM outputs,
// with a clock prescaler and period-aligned duty updates.
module spi_pwm_multi #(
  parameter int NUM_CH      = 16,
  parameter int DUTY_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  spi_pwm_multi_if.slave bus
);

  localparam int                NB         = NUM_CH / 8;
  localparam logic [6:0]        PRESC_ADDR = 7'(2 * NB + NUM_CH);
  localparam logic [DUTY_W-1:0] CNT_LAST   = DUTY_W'((1 << DUTY_W) - 2);

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v >= 5'd17) ? 5'd17 : v + 5'd1;
  endfunction

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] copi_sync;
  logic [SYNC_STAGES-1:0] ncs_sync;
  logic                   sclk_q;
  logic                   ncs_q;
  logic                   sclk_s;
  logic                   copi_s;
  logic                   ncs_s;
  logic                   sclk_rise;
  logic                   ncs_fall;
  logic                   ncs_rise;

  logic                   in_frame_p0;
  logic [4:0]             bit_cnt_p0;
  logic [15:0]            shreg_p0;

  logic                   wr_vld_p1;
  logic                   err_p1;
  logic [6:0]             wr_addr_p1;
  logic [7:0]             wr_data_p1;

  logic [NUM_CH-1:0]      out_en;
  logic [NUM_CH-1:0]      pwm_en;
  logic [7:0]             presc;
  logic [DUTY_W-1:0]      duty_pend [NUM_CH];
  logic [DUTY_W-1:0]      duty_act  [NUM_CH];
  logic [7:0]             pc;
  logic [DUTY_W-1:0]      cnt;
  logic                   tick;
  logic                   wrap;
  logic [NUM_CH-1:0]      pwm;
  logic [NUM_CH-1:0]      out_q;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign ncs_fall  = ~ncs_s & ncs_q;
  assign ncs_rise  = ncs_s & ~ncs_q;

  // Stage p0: synchronise pins, detect edges, shift the frame in.
  // ncs flops reset low so an idle-high ncs after reset only looks like a rising edge,
  // which is ignored because no frame was started.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync   <= '0;
      copi_sync   <= '0;
      ncs_sync    <= '0;
      sclk_q      <= 1'b0;
      ncs_q       <= 1'b0;
      in_frame_p0 <= 1'b0;
      bit_cnt_p0  <= '0;
      shreg_p0    <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk_in};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], bus.copi_in};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], bus.ncs_in};
      sclk_q    <= sclk_s;
      ncs_q     <= ncs_s;
      if (ncs_fall) begin
        in_frame_p0 <= 1'b1;
        if (sclk_rise) begin
          bit_cnt_p0 <= 5'd1;
          shreg_p0   <= {15'b0, copi_s};
        end else begin
          bit_cnt_p0 <= '0;
          shreg_p0   <= '0;
        end
      end else if (ncs_rise) begin
        in_frame_p0 <= 1'b0;
      end else if (sclk_rise && !ncs_s && in_frame_p0) begin
        bit_cnt_p0 <= sat_inc(bit_cnt_p0);
        shreg_p0   <= {shreg_p0[14:0], copi_s};
      end
    end
  end

  // Stage p1: frame check on ncs release; these flops are also the status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_vld_p1  <= 1'b0;
      err_p1     <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else begin
      wr_vld_p1 <= 1'b0;
      err_p1    <= 1'b0;
      if (ncs_rise && in_frame_p0) begin
        wr_addr_p1 <= shreg_p0[14:8];
        wr_data_p1 <= shreg_p0[7:0];
        if (bit_cnt_p0 != 5'd16) begin
          err_p1 <= 1'b1;
        end else if (shreg_p0[15]) begin
          if (shreg_p0[14:8] <= PRESC_ADDR) wr_vld_p1 <= 1'b1;
          else                              err_p1    <= 1'b1;
        end
      end
    end
  end

  // Stage p2: register file commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_en <= '0;
      pwm_en <= '0;
      presc  <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) duty_pend[ch] <= '0;
    end else if (wr_vld_p1) begin
      for (int k = 0; k < NB; k++) begin
        if (wr_addr_p1 == 7'(k))      out_en[8*k +: 8] <= wr_data_p1;
        if (wr_addr_p1 == 7'(NB + k)) pwm_en[8*k +: 8] <= wr_data_p1;
      end
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (wr_addr_p1 == 7'(2 * NB + ch)) duty_pend[ch] <= wr_data_p1[DUTY_W-1:0];
      end
      if (wr_addr_p1 == PRESC_ADDR) presc <= wr_data_p1;
    end
  end

  assign tick = (pc >= presc);
  assign wrap = tick && (cnt == CNT_LAST);

  // Timebase: pending duties are latched on the wrap tick, so a commit in that same cycle
  // naturally lands one period later.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc  <= '0;
      cnt <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) duty_act[ch] <= '0;
    end else begin
      pc <= tick ? 8'd0 : pc + 8'd1;
      if (tick) cnt <= wrap ? '0 : cnt + DUTY_W'(1);
      if (wrap) begin
        for (int ch = 0; ch < NUM_CH; ch++) duty_act[ch] <= duty_pend[ch];
      end
    end
  end

  always_comb begin
    pwm = '0;
    for (int ch = 0; ch < NUM_CH; ch++) pwm[ch] = (cnt < duty_act[ch]);
  end

  // Output stage: registered channel levels.
  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= out_en & (~pwm_en | pwm);
  end

  assign bus.out        = out_q;
  assign bus.frame_done = wr_vld_p1;
  assign bus.frame_err  = err_p1;

endmodule

// File: tb/tb_spi_pwm_multi.sv
// Directed bench for spi_pwm_multi (NUM_CH=16, DUTY_W=8): SPI frames, pulse counting and
// PWM high/low run-length measurement on out[0].
module tb_spi_pwm_multi;

  localparam int NUM_CH = 16;
  localparam int H      = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  spi_pwm_multi_if #(.NUM_CH(NUM_CH)) bus_if ();

  spi_pwm_multi #(.NUM_CH(NUM_CH), .DUTY_W(8), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int exp_done = 0;
  int exp_err  = 0;
  int hi_len [2];
  int lo_len [2];
  int hcount;

  always @(negedge clk) begin
    if (bus_if.frame_done === 1'b1) done_cnt++;
    if (bus_if.frame_err === 1'b1)  err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic spi_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus_if.copi_in = v[i];
      repeat (H) @(negedge clk);
      bus_if.sclk_in = 1'b1;
      repeat (H) @(negedge clk);
      bus_if.sclk_in = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [31:0] v, input int n);
    bus_if.ncs_in = 1'b0;
    repeat (H) @(negedge clk);
    spi_bits(v, n);
    repeat (H) @(negedge clk);
    bus_if.ncs_in  = 1'b1;
    bus_if.copi_in = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    spi_frame({16'b0, 1'b1, a, d}, 16);
    exp_done++;
  endtask

  task automatic wait_out0(input logic lvl, output bit ok);
    int n = 0;
    while (bus_if.out[0] !== lvl && n < 4000) begin
      @(negedge clk);
      n++;
    end
    ok = (bus_if.out[0] === lvl);
  endtask

  // Lengths of n consecutive high/low runs starting at the next rising edge of out[0].
  task automatic meas_pulses(input int n);
    bit ok;
    int hi;
    int lo;
    for (int k = 0; k < 2; k++) begin
      hi_len[k] = 0;
      lo_len[k] = 0;
    end
    wait_out0(1'b0, ok);
    if (!ok) return;
    wait_out0(1'b1, ok);
    if (!ok) return;
    for (int k = 0; k < n; k++) begin
      hi = 0;
      while (bus_if.out[0] === 1'b1 && hi < 4000) begin
        hi++;
        @(negedge clk);
      end
      lo = 0;
      while (bus_if.out[0] === 1'b0 && lo < 4000) begin
        lo++;
        @(negedge clk);
      end
      hi_len[k] = hi;
      lo_len[k] = lo;
    end
  endtask

  task automatic count_high(input int n, output int c);
    c = 0;
    repeat (n) begin
      if (bus_if.out[0] === 1'b1) c++;
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst            = 1'b1;
    bus_if.sclk_in = 1'b0;
    bus_if.copi_in = 1'b0;
    bus_if.ncs_in  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_out", 32'(bus_if.out), 32'h0);
    check("reset_done", 32'(bus_if.frame_done), 32'h0);
    check("reset_err", 32'(bus_if.frame_err), 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_out", 32'(bus_if.out), 32'h0);
    check("idle_pulses", 32'(done_cnt + err_cnt), 32'h0);

    // Static enables only
    wr(7'h00, 8'hA5);
    repeat (3) @(negedge clk);
    check("static_done", 32'(done_cnt), 32'(exp_done));
    check("static_err", 32'(err_cnt), 32'(exp_err));
    check("static_out", 32'(bus_if.out), 32'h00A5);

    // PWM on channel 0, presc 0
    wr(7'h00, 8'h01);
    wr(7'h02, 8'h01);
    wr(7'h04, 8'h80);
    wr(7'h14, 8'h00);
    repeat (600) @(negedge clk);
    meas_pulses(1);
    check("d80_high", 32'(hi_len[0]), 32'd128);
    check("d80_low", 32'(lo_len[0]), 32'd127);
    wr(7'h04, 8'hFF);
    repeat (600) @(negedge clk);
    count_high(300, hcount);
    check("dff_high", 32'(hcount), 32'd300);
    wr(7'h04, 8'h00);
    repeat (600) @(negedge clk);
    count_high(300, hcount);
    check("d00_high", 32'(hcount), 32'd0);
    check("pwm_done", 32'(done_cnt), 32'(exp_done));

    // Mid-period duty change: commit lands inside the high phase of the period after F
    wr(7'h04, 8'h40);
    repeat (600) @(negedge clk);
    wait_out0(1'b1, ok);
    wait_out0(1'b0, ok);
    fork
      begin
        repeat (117) @(negedge clk);
        wr(7'h04, 8'hC0);
      end
      meas_pulses(2);
    join
    check("upd_high0", 32'(hi_len[0]), 32'd64);
    check("upd_low0", 32'(lo_len[0]), 32'd191);
    check("upd_high1", 32'(hi_len[1]), 32'd192);
    check("upd_low1", 32'(lo_len[1]), 32'd63);

    // Rejected and ignored frames aimed at out_en[15:8]
    spi_frame(32'h0000_40FF, 15);
    exp_err++;
    check("short_err", 32'(err_cnt), 32'(exp_err));
    spi_frame(32'h0001_03FF, 17);
    exp_err++;
    check("long_err", 32'(err_cnt), 32'(exp_err));
    spi_frame(32'h0000_FFFF, 16);
    exp_err++;
    check("badaddr_err", 32'(err_cnt), 32'(exp_err));
    check("bad_done", 32'(done_cnt), 32'(exp_done));
    check("bad_out_hi", 32'(bus_if.out[15:8]), 32'h0);
    spi_frame(32'h0000_01FF, 16);
    check("read_err", 32'(err_cnt), 32'(exp_err));
    check("read_done", 32'(done_cnt), 32'(exp_done));
    check("read_out_hi", 32'(bus_if.out[15:8]), 32'h0);

    // Prescaler 3
    wr(7'h14, 8'h03);
    wr(7'h04, 8'h80);
    repeat (2200) @(negedge clk);
    meas_pulses(1);
    check("presc_high", 32'(hi_len[0]), 32'd512);
    check("presc_low", 32'(lo_len[0]), 32'd508);

    // Reset in the middle of a write to out_en[15:8]
    bus_if.ncs_in = 1'b0;
    repeat (H) @(negedge clk);
    spi_bits(32'h81, 8);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    spi_bits(32'hFF, 8);
    repeat (H) @(negedge clk);
    bus_if.ncs_in = 1'b1;
    repeat (12) @(negedge clk);
    check("rstmid_out", 32'(bus_if.out), 32'h0);
    check("rstmid_done", 32'(done_cnt), 32'(exp_done));
    check("rstmid_err", 32'(err_cnt), 32'(exp_err));
    wr(7'h01, 8'h3C);
    repeat (3) @(negedge clk);
    check("post_rst_out", 32'(bus_if.out), 32'h3C00);
    check("post_rst_done", 32'(done_cnt), 32'(exp_done));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
